// File: rtl/sfu_out_packer.sv
// SFU result packer: absorbs valid-only 512-bit beats in a FWFT FIFO and re-presents them on
// ready/valid, optionally packing two FP32 beats into one BF16 beat with round-to-nearest-even.
module sfu_out_packer #(
  parameter int unsigned DataWidth = 512,
  parameter int unsigned FP_WIDTH  = 32,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned CNT_WIDTH = 10
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [CNT_WIDTH-1:0] beat_num_i,
  input  logic                 pack_en_i,
  input  logic                 in_valid_i,
  input  logic [DataWidth-1:0] in_bits_i,
  output logic                 in_ready_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [DataWidth-1:0] out_bits_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 overflow_o
);

  localparam int unsigned Lanes = DataWidth / FP_WIDTH;
  localparam int unsigned HalfW = DataWidth / 2;
  localparam int unsigned AddrW = $clog2(DEPTH);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] n_q, n_d, cnt_q, cnt_d;
  logic                 pack_q, pack_d;
  logic                 ovf_q, ovf_d;
  logic                 done_zero_q, done_zero_d;
  logic [HalfW-1:0]     stage_q, stage_d;
  logic [HalfW-1:0]     in_bf16;
  logic [DataWidth-1:0] push_data;
  logic                 push, pop, wr_en, drain_done;
  logic                 empty, full;
  logic [AddrW:0]       wptr_q, rptr_q;
  logic [DataWidth-1:0] mem_q [DEPTH];

  // NaN is canonicalised; everything else rounds RNE with a natural carry into the exponent.
  function automatic logic [15:0] to_bf16(input logic [31:0] x);
    logic nan, rnd;
    nan = (&x[30:23]) & (|x[22:0]);
    rnd = x[15] & ((|x[14:0]) | x[16]);
    if (nan) return {x[31], 15'h7FC0};
    return x[31:16] + {15'd0, rnd};
  endfunction

  always_comb begin
    in_bf16 = '0;
    for (int unsigned i = 0; i < Lanes; i++) begin
      in_bf16[16*i +: 16] = to_bf16(in_bits_i[FP_WIDTH*i +: 32]);
    end
  end

  assign empty       = (wptr_q == rptr_q);
  assign full        = (wptr_q[AddrW] != rptr_q[AddrW]) &&
                       (wptr_q[AddrW-1:0] == rptr_q[AddrW-1:0]);
  assign out_valid_o = ~empty;
  assign pop         = out_valid_o & out_ready_i;
  assign wr_en       = push & (~full | pop);
  assign in_ready_o  = ~full;
  assign out_bits_o  = out_valid_o ? mem_q[rptr_q[AddrW-1:0]] : '0;
  assign busy_o      = (state_q != StIdle);
  assign done_o      = drain_done | done_zero_q;
  assign overflow_o  = ovf_q;

  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    pack_d      = pack_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    stage_d     = stage_q;
    done_zero_d = 1'b0;
    push        = 1'b0;
    push_data   = in_bits_i;
    drain_done  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          n_d    = beat_num_i;
          pack_d = pack_en_i;
          cnt_d  = '0;
          ovf_d  = 1'b0;
          if (beat_num_i != '0) state_d = StRun;
          else                  done_zero_d = 1'b1;
        end
      end
      StRun: begin
        if (in_valid_i) begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
          if (cnt_d == n_q) state_d = StDrain;
          if (!pack_q) begin
            push = 1'b1;
          end else if (!cnt_q[0]) begin
            stage_d = in_bf16;
            // An odd-length job flushes its final beat with an empty upper half.
            if (cnt_d == n_q) begin
              push      = 1'b1;
              push_data = {{HalfW{1'b0}}, in_bf16};
            end
          end else begin
            push      = 1'b1;
            push_data = {in_bf16, stage_q};
          end
        end
      end
      StDrain: begin
        if (empty) begin
          state_d    = StIdle;
          drain_done = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (push && full && !pop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      n_q         <= '0;
      pack_q      <= 1'b0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      done_zero_q <= 1'b0;
      stage_q     <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      pack_q      <= pack_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      done_zero_q <= done_zero_d;
      stage_q     <= stage_d;
      if (wr_en) wptr_q <= wptr_q + 1'b1;
      if (pop)   rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wptr_q[AddrW-1:0]] <= push_data;
  end

endmodule

// File: tb/tb_sfu_out_packer.sv
// Directed bench for sfu_out_packer: passthrough, BF16 packing, overflow, full-FIFO
// push/pop, empty jobs and mid-job reset.
module tb_sfu_out_packer;

  logic         clk, rst_n, start, pack_en, in_valid, in_ready;
  logic         out_valid, out_ready, busy, done, overflow;
  logic [9:0]   beat_num;
  logic [511:0] in_bits, out_bits, expv;
  int           n_cmp, n_err;

  sfu_out_packer dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (start),
    .beat_num_i (beat_num),
    .pack_en_i  (pack_en),
    .in_valid_i (in_valid),
    .in_bits_i  (in_bits),
    .in_ready_o (in_ready),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_bits_o (out_bits),
    .busy_o     (busy),
    .done_o     (done),
    .overflow_o (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [511:0] beat(input int k);
    return {480'd0, 32'(k)};
  endfunction

  function automatic logic [511:0] rep32(input logic [31:0] w);
    return {16{w}};
  endfunction

  task automatic start_job(input logic [9:0] n, input logic p);
    start = 1'b1; beat_num = n; pack_en = p;
    cycle();
    start = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst_n = 1'b0; start = 1'b0; beat_num = '0; pack_en = 1'b0;
    in_valid = 1'b0; in_bits = '0; out_ready = 1'b1;
    #12;
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_overflow", overflow, 1'b0);
    chk1("rst_in_ready", in_ready, 1'b1);
    chkw("rst_out_bits", out_bits, '0);
    rst_n = 1'b1;
    cycle();

    // 1: passthrough, one-cycle latency
    start_job(10'd4, 1'b0);
    chk1("t1_busy", busy, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      in_valid = 1'b1; in_bits = beat(k);
      cycle();
      chk1("t1_valid", out_valid, 1'b1);
      chkw("t1_bits", out_bits, beat(k));
    end
    in_valid = 1'b0; #1;
    chk1("t1_done_early", done, 1'b0);
    cycle();
    chk1("t1_done", done, 1'b1);
    chk1("t1_empty", out_valid, 1'b0);
    cycle();
    chk1("t1_done_once", done, 1'b0);
    chk1("t1_idle", busy, 1'b0);

    // 2: pack, odd N, RNE ties
    start_job(10'd3, 1'b1);
    in_valid = 1'b1; in_bits = rep32(32'h3F818000);
    cycle();
    chk1("t2_staged", out_valid, 1'b0);
    in_bits = rep32(32'h3F808000);
    cycle();
    chk1("t2_v0", out_valid, 1'b1);
    chkw("t2_b0", out_bits, {{16{16'h3F80}}, {16{16'h3F82}}});
    in_bits = rep32(32'h3F807FFF);
    cycle();
    in_valid = 1'b0;
    chkw("t2_b1", out_bits, {256'd0, {16{16'h3F80}}});
    chk1("t2_done_early", done, 1'b0);
    cycle();
    chk1("t2_done", done, 1'b1);
    cycle();

    // 3: pack specials, and output held stable while stalled
    start_job(10'd1, 1'b1);
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_bits = rep32(32'h3F818000);
    in_bits[31:0]   = 32'h7F7FFFFF;
    in_bits[63:32]  = 32'h7F800001;
    in_bits[95:64]  = 32'hFFC00000;
    in_bits[127:96] = 32'h80000000;
    expv = {256'd0, {16{16'h3F82}}};
    expv[15:0]  = 16'h7F80;
    expv[31:16] = 16'h7FC0;
    expv[47:32] = 16'hFFC0;
    expv[63:48] = 16'h8000;
    cycle();
    in_valid = 1'b0;
    chkw("t3_specials", out_bits, expv);
    cycle();
    chkw("t3_stable", out_bits, expv);
    chk1("t3_stable_v", out_valid, 1'b1);
    out_ready = 1'b1;
    cycle();
    chk1("t3_done", done, 1'b1);
    cycle();

    // 4: overflow with stalled sink
    start_job(10'd10, 1'b0);
    out_ready = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      if (k == 9) begin
        chk1("t4_full", in_ready, 1'b0);
        chk1("t4_no_ovf_yet", overflow, 1'b0);
      end
      in_valid = 1'b1; in_bits = beat(k);
      cycle();
    end
    in_valid = 1'b0;
    chk1("t4_overflow", overflow, 1'b1);
    chk1("t4_drain_busy", busy, 1'b1);
    chk1("t4_no_done", done, 1'b0);
    out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      chkw("t4_bits", out_bits, beat(k));
      cycle();
    end
    chk1("t4_done", done, 1'b1);
    chk1("t4_ovf_sticky", overflow, 1'b1);
    cycle();

    // 5: full FIFO with simultaneous push and pop
    start_job(10'd10, 1'b0);
    chk1("t5_ovf_cleared", overflow, 1'b0);
    out_ready = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      in_valid = 1'b1; in_bits = beat(k);
      cycle();
    end
    out_ready = 1'b1;
    for (int k = 9; k <= 10; k++) begin
      in_bits = beat(k); #1;
      chk1("t5_full", in_ready, 1'b0);
      cycle();
    end
    in_valid = 1'b0;
    chk1("t5_no_ovf", overflow, 1'b0);
    for (int k = 1 + 2; k <= 10; k++) begin
      chkw("t5_bits", out_bits, beat(k));
      cycle();
    end
    chk1("t5_done", done, 1'b1);
    cycle();

    // 6: zero-length job, then reset mid-run and a fresh job
    start_job(10'd0, 1'b0);
    chk1("t6_zero_done", done, 1'b1);
    chk1("t6_zero_idle", busy, 1'b0);
    chk1("t6_zero_nout", out_valid, 1'b0);
    cycle();
    chk1("t6_zero_pulse", done, 1'b0);
    start_job(10'd4, 1'b0);
    out_ready = 1'b0;
    in_valid = 1'b1; in_bits = beat(7);
    cycle();
    cycle();
    in_valid = 1'b0;
    rst_n = 1'b0; #1;
    chk1("t6_rst_valid", out_valid, 1'b0);
    chk1("t6_rst_busy", busy, 1'b0);
    chk1("t6_rst_ready", in_ready, 1'b1);
    rst_n = 1'b1; out_ready = 1'b1;
    cycle();
    start_job(10'd2, 1'b0);
    in_valid = 1'b1; in_bits = beat(32'hA);
    cycle();
    chkw("t6_fresh0", out_bits, beat(32'hA));
    in_bits = beat(32'hB);
    cycle();
    in_valid = 1'b0;
    chkw("t6_fresh1", out_bits, beat(32'hB));
    cycle();
    chk1("t6_fresh_done", done, 1'b1);
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
